wash_cycle_controller: RTL and testbench
========================================

// Module: wash_cycle_controller
// PURPOSE
//   Washing-machine cycle sequencer; the initiator side of the phase timer.
//   Steps IDLE->FILL->WASH->RINSE->SPIN->DONE.
//   In each phase it loads timer_period and timer_clk_freq, holds timer_enable, and advances on timer_done.
//   Drives the water valve and motor outputs. Sits between the front-panel inputs and the timer instance.
// PARAMETERS
//   CLK_FREQ  16'd5  ticks per second, driven constantly on timer_clk_freq
//   FILL_T    16'd2  FILL phase length, seconds
//   WASH_T    16'd5  WASH phase length, seconds
//   RINSE_T   16'd2  RINSE (and RINSE2) phase length, seconds
//   SPIN_T    16'd1  SPIN phase length, seconds
// PORTS
//   clk             in   1   system clock
//   reset           in   1   asynchronous, active-high reset
//   start           in   1   level; begins a cycle when sampled high in IDLE
//   door_closed     in   1   low = door open
//   pause           in   1   level; high suspends the active phase
//   timer_done      in   1   level from timer: period elapsed
//   timer_enable    out  1   run request to timer; low clears timer count
//   timer_period    out  16  current phase length, seconds
//   timer_clk_freq  out  16  = CLK_FREQ
//   state           out  3   IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4 DONE=5 RINSE2=6
//   water_valve     out  1   high in FILL, RINSE, RINSE2
//   motor_on        out  1   high in WASH, RINSE, RINSE2, SPIN
//   spin_fast       out  1   high in SPIN only
//   busy            out  1   high in any state except IDLE
//   cycle_done      out  1   one-cycle pulse while in DONE
// BEHAVIOUR
//   - One clock, clk. reset is asynchronous and active-high.
//   - Reset, asserted at any time including mid-phase: state=IDLE, timer_enable=0, timer_period=0.
//     Also on reset: all actuator outputs=0, busy=0, cycle_done=0, armed=0.
//   - All outputs are registered or decoded from registered state; no combinational input->output path.
//   - IDLE: on start=1 && door_closed=1, go to FILL next edge. start with door open is ignored.
//   - Phase entry (every phase): first cycle is a GAP: timer_enable=0 and timer_period loaded.
//     Internal armed=0; timer_done is ignored in this cycle, so a stale done cannot skip a phase.
//     Next cycle: armed=1, timer_enable=1.
//   - Advance: in a phase with armed=1, timer_enable=1, timer_done=1, move to the next state on that edge.
//     The next phase's GAP cycle follows immediately.
//   - Order: FILL->WASH->RINSE->[RINSE2]->SPIN->DONE->IDLE. DONE lasts exactly 1 cycle.
//   - Suspend: pause=1 or door_closed=0 in any phase: timer_enable=0, armed=0.
//     Water_valve, motor_on and spin_fast are forced low; state is held.
//     On release, the phase restarts from its full period via a fresh GAP cycle.
//   - Simultaneous suspend and timer_done: suspend wins; no advance.
//   - start while busy: ignored. start held high through DONE: a new cycle begins from IDLE on the next edge.
//   - timer_period widths: parameters are 16-bit and loaded unmodified. Period 0 is legal.
//     A 0-second phase still costs the GAP cycle plus timer response.
//   - Timer interface contract: the timer counts only while enable=1, clears its count when enable=0,
//     and asserts done after timer_period*timer_clk_freq enabled cycles.
// CONFIGURATION
//   EXTRA_RINSE_EN defined: adds state RINSE2 (=6) between RINSE and SPIN.
//     RINSE2 length is RINSE_T, with the same outputs as RINSE.
//   EXTRA_RINSE_EN undefined: RINSE goes directly to SPIN; encoding 6 is unreachable.
// TESTING (bench timer model: done high from the (T*F)th enabled cycle until enable drops; F=5)
//   T1 reset: reset=1 mid-WASH -> next sample shows state=0, timer_enable=0, motor_on=0, busy=0.
//   T2 full cycle: start pulse, door closed -> FILL 11 cycles (period=2), WASH 26 (period=5).
//      Then RINSE 11 (period=2), SPIN 6 (period=1), cycle_done pulse of 1 cycle, then state=0.
//   T3 door interlock: start with door_closed=0 -> state stays 0.
//      Open the door 4 cycles into WASH -> motor_on=0, timer_enable=0.
//      Close it -> GAP, then WASH runs the full 25 enabled cycles.
//   T4 pause/done race: pause=1 in the same cycle timer_done=1 in RINSE -> state stays 3.
//      Release -> RINSE restarts (11 cycles).
//   T5 stale done: hold timer_done=1 across the FILL->WASH edge -> WASH not skipped.
//      GAP cycle shows timer_enable=0, timer_period=5.
//   T6 EXTRA_RINSE_EN build: full cycle visits state 6 for 11 cycles between 3 and 4.
//      Default build: state never equals 6.

Source files
------------

// File: rtl/wash_cycle_controller.sv
// Washing-machine cycle sequencer driving an external phase timer, valve and motor.
// Define EXTRA_RINSE_EN to insert a second rinse phase (RINSE2) between RINSE and SPIN.
module wash_cycle_controller #(
    parameter logic [15:0] CLK_FREQ = 16'd5,
    parameter logic [15:0] FILL_T   = 16'd2,
    parameter logic [15:0] WASH_T   = 16'd5,
    parameter logic [15:0] RINSE_T  = 16'd2,
    parameter logic [15:0] SPIN_T   = 16'd1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        door_closed_i,
    input  logic        pause_i,
    input  logic        timer_done_i,
    output logic        timer_enable_o,
    output logic [15:0] timer_period_o,
    output logic [15:0] timer_clk_freq_o,
    output logic [2:0]  state_o,
    output logic        water_valve_o,
    output logic        motor_on_o,
    output logic        spin_fast_o,
    output logic        busy_o,
    output logic        cycle_done_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_WASH   = 3'd2,
        S_RINSE  = 3'd3,
        S_SPIN   = 3'd4,
        S_DONE   = 3'd5,
        S_RINSE2 = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic        act_q, act_d;
    logic [15:0] period_q, period_d;
    logic        in_phase;
    logic        suspend;
    logic        advance;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            armed_q  <= 1'b0;
            act_q    <= 1'b0;
            period_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            act_q    <= act_d;
            period_q <= period_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_phase = state_q inside {S_FILL, S_WASH, S_RINSE, S_RINSE2, S_SPIN};
        suspend  = pause_i || !door_closed_i;
        // armed_q is low during the entry GAP, so a done left over from the previous phase is ignored
        advance  = in_phase && armed_q && timer_done_i && !suspend;

        case (state_q)
            S_IDLE:  if (start_i && door_closed_i) state_d = S_FILL;
            S_FILL:  if (advance) state_d = S_WASH;
            S_WASH:  if (advance) state_d = S_RINSE;
`ifdef EXTRA_RINSE_EN
            S_RINSE:  if (advance) state_d = S_RINSE2;
            S_RINSE2: if (advance) state_d = S_SPIN;
`else
            S_RINSE:  if (advance) state_d = S_SPIN;
`endif
            S_SPIN:  if (advance) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Suspension drops armed, so release always restarts the phase through a fresh GAP
        armed_d = in_phase && !suspend && !advance;
        act_d   = !suspend;

        case (state_d)
            S_FILL:   period_d = FILL_T;
            S_WASH:   period_d = WASH_T;
            S_RINSE:  period_d = RINSE_T;
            S_RINSE2: period_d = RINSE_T;
            S_SPIN:   period_d = SPIN_T;
            default:  period_d = 16'd0;
        endcase
    end

    assign timer_enable_o   = armed_q;
    assign timer_period_o   = period_q;
    assign timer_clk_freq_o = CLK_FREQ;
    assign state_o          = state_q;
    assign water_valve_o    = act_q && (state_q inside {S_FILL, S_RINSE, S_RINSE2});
    assign motor_on_o       = act_q && (state_q inside {S_WASH, S_RINSE, S_RINSE2, S_SPIN});
    assign spin_fast_o      = act_q && (state_q == S_SPIN);
    assign busy_o           = (state_q != S_IDLE);
    assign cycle_done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Scoreboard bench for wash_cycle_controller: expected phase segments are queued at start,
// and popped as the monitor sees each phase end. Includes a behavioural phase timer.
module tb_wash_cycle_controller;

    localparam int F = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, door_closed, pause, timer_done;
    logic        timer_enable;
    logic [15:0] timer_period, timer_clk_freq;
    logic [2:0]  state;
    logic        water_valve, motor_on, spin_fast, busy, cycle_done;

    logic        force_done;
    logic        mon_en;
    int          tcnt;
    int          checks = 0;
    int          errors = 0;
    int          seen6 = 0;

    typedef struct {
        logic [2:0] st;
        int         len;
    } seg_t;
    seg_t exp_q[$];

    wash_cycle_controller dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .start_i          (start),
        .door_closed_i    (door_closed),
        .pause_i          (pause),
        .timer_done_i     (timer_done),
        .timer_enable_o   (timer_enable),
        .timer_period_o   (timer_period),
        .timer_clk_freq_o (timer_clk_freq),
        .state_o          (state),
        .water_valve_o    (water_valve),
        .motor_on_o       (motor_on),
        .spin_fast_o      (spin_fast),
        .busy_o           (busy),
        .cycle_done_o     (cycle_done)
    );

    always #5 clk = ~clk;

    // Phase timer: counts enabled cycles, clears when disabled, done from the (T*F)th enabled cycle
    always @(posedge clk or posedge reset) begin
        if (reset)              tcnt <= 0;
        else if (!timer_enable) tcnt <= 0;
        else                    tcnt <= tcnt + 1;
    end
    assign timer_done = force_done ||
        (timer_enable && (tcnt + 1 >= int'(timer_period) * int'(timer_clk_freq)));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] per_of(input logic [2:0] s);
        case (s)
            3'd1:       return 16'd2;
            3'd2:       return 16'd5;
            3'd3, 3'd6: return 16'd2;
            3'd4:       return 16'd1;
            default:    return 16'd0;
        endcase
    endfunction

    // {water_valve, motor_on, spin_fast} while not suspended
    function automatic logic [2:0] act_of(input logic [2:0] s);
        case (s)
            3'd1:       return 3'b100;
            3'd2:       return 3'b010;
            3'd3, 3'd6: return 3'b110;
            3'd4:       return 3'b011;
            default:    return 3'b000;
        endcase
    endfunction

    task automatic push(input logic [2:0] st, input int len);
        seg_t s;
        s.st  = st;
        s.len = len;
        exp_q.push_back(s);
    endtask

    task automatic push_cycle(input int wash_len, input int rinse_len);
        push(3'd1, 2 * F + 1);
        push(3'd2, wash_len);
        push(3'd3, rinse_len);
`ifdef EXTRA_RINSE_EN
        push(3'd6, 2 * F + 1);
`endif
        push(3'd4, 1 * F + 1);
        push(3'd5, 1);
    endtask

    // Monitor: measure each non-IDLE segment, check its entry GAP cycle, score its length
    logic [2:0] cur_st;
    int         run;
    always @(negedge clk) begin
        if (!mon_en) begin
            cur_st = state;
            run    = 0;
        end else begin
            if (state == 3'd6) seen6++;
            if (state == cur_st) run++;
            else begin
                if (cur_st != 3'd0) begin
                    if (exp_q.size() == 0) chk("seg_unexpected", cur_st, 3'd0);
                    else begin
                        seg_t e;
                        e = exp_q.pop_front();
                        chk("seg_state", cur_st, e.st);
                        chk("seg_len", run, e.len);
                    end
                end
                cur_st = state;
                run    = 1;
                if (state != 3'd0) begin
                    chk("gap_enable", timer_enable, 1'b0);
                    chk("gap_period", timer_period, per_of(state));
                    chk("gap_act", {water_valve, motor_on, spin_fast}, act_of(state));
                    chk("gap_busy", busy, 1'b1);
                    chk("gap_cycle_done", cycle_done, state == 3'd5);
                end
            end
        end
    end

    task automatic wait_state(input logic [2:0] st, input int budget);
        int n = 0;
        while (state !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (state !== st) chk("timeout_state", state, st);
    endtask

    task automatic wait_idle();
        wait_state(3'd0, 400);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; door_closed = 1'b1; pause = 1'b0;
        force_done = 1'b0; mon_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", state, 3'd0);
        chk("rst_enable", timer_enable, 1'b0);
        chk("rst_period", timer_period, 16'd0);
        chk("rst_act", {water_valve, motor_on, spin_fast}, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cycle_done", cycle_done, 1'b0);
        chk("clk_freq", timer_clk_freq, 16'd5);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Start with the door open is ignored
        door_closed = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        chk("door_open_start", state, 3'd0);
        start = 1'b0; door_closed = 1'b1;
        @(negedge clk);

        // Plain full cycle
        push_cycle(5 * F + 1, 2 * F + 1);
        pulse_start();
        wait_idle();
        chk("q_empty_full", exp_q.size(), 0);

        // Stale done held across FILL->WASH must not skip WASH
        push_cycle(5 * F + 1, 2 * F + 1);
        pulse_start();
        wait_state(3'd1, 10);
        repeat (10) @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        chk("stale_state", state, 3'd2);
        chk("stale_enable", timer_enable, 1'b0);
        chk("stale_period", timer_period, 16'd5);
        force_done = 1'b0;
        wait_idle();
        chk("q_empty_stale", exp_q.size(), 0);

        // Door opened 4 cycles into WASH for 5 edges: 4 + 5 + full 25 enabled cycles
        push_cycle(4 + 5 + 5 * F, 2 * F + 1);
        pulse_start();
        wait_state(3'd2, 40);
        repeat (3) @(negedge clk);
        door_closed = 1'b0;
        @(negedge clk);
        chk("door_motor", motor_on, 1'b0);
        chk("door_enable", timer_enable, 1'b0);
        chk("door_state", state, 3'd2);
        repeat (4) @(negedge clk);
        door_closed = 1'b1;
        wait_idle();
        chk("q_empty_door", exp_q.size(), 0);

        // Pause coincident with timer_done in RINSE: 11 + 3 + fresh 10 enabled cycles
        push_cycle(5 * F + 1, 11 + 3 + 2 * F);
        pulse_start();
        wait_state(3'd3, 60);
        repeat (10) @(negedge clk);
        chk("race_done_high", timer_done, 1'b1);
        pause = 1'b1;
        @(negedge clk);
        chk("race_state", state, 3'd3);
        chk("race_enable", timer_enable, 1'b0);
        chk("race_valve", water_valve, 1'b0);
        repeat (2) @(negedge clk);
        pause = 1'b0;
        wait_idle();
        chk("q_empty_race", exp_q.size(), 0);

        // Start held through DONE restarts from IDLE on the following edge
        push_cycle(5 * F + 1, 2 * F + 1);
        push_cycle(5 * F + 1, 2 * F + 1);
        start = 1'b1;
        wait_state(3'd5, 120);
        @(negedge clk);
        chk("held_idle", state, 3'd0);
        @(negedge clk);
        chk("held_refill", state, 3'd1);
        start = 1'b0;
        wait_idle();
        chk("q_empty_held", exp_q.size(), 0);

        // Asynchronous reset in the middle of WASH
        push_cycle(5 * F + 1, 2 * F + 1);
        pulse_start();
        wait_state(3'd2, 40);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        #1;
        chk("arst_state", state, 3'd0);
        chk("arst_enable", timer_enable, 1'b0);
        chk("arst_motor", motor_on, 1'b0);
        chk("arst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("arst_hold", state, 3'd0);
        mon_en = 1'b1;
        @(negedge clk);

        // Recovery after reset
        push_cycle(5 * F + 1, 2 * F + 1);
        pulse_start();
        wait_idle();
        chk("q_empty_recover", exp_q.size(), 0);

`ifdef EXTRA_RINSE_EN
        chk("rinse2_seen", seen6 != 0, 1'b1);
`else
        chk("rinse2_unreached", seen6, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
